// File: rtl/udp_cmd_rx_filter.sv
// Store-and-forward filter between the UDP RX stack and the command parser; replays one good packet at a time.
// Optional build macro UDP_FILTER_ANY_SRC_EN: accept any source IP and match on the destination port only.
module udp_cmd_rx_filter #(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] IP_ADRESS   = {8'd192, 8'd168, 8'd1, 8'd128},
    parameter logic [15:0] PORT_NUMBER = 16'd1234
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx_udp_hdr_valid,
    output logic        o_rx_udp_hdr_ready,
    input  logic [31:0] i_rx_udp_ip_source_ip,
    input  logic [15:0] i_rx_udp_dest_port,
    input  logic [7:0]  i_rx_udp_payload_axis_tdata,
    input  logic        i_rx_udp_payload_axis_tvalid,
    input  logic        i_rx_udp_payload_axis_tlast,
    input  logic        i_rx_udp_payload_axis_tuser,
    output logic        o_rx_udp_payload_axis_tready,
    output logic [7:0]  o_payload_axis_tdata,
    output logic        o_payload_axis_tvalid,
    output logic        o_payload_axis_tlast,
    input  logic        i_payload_axis_tready,
    output logic [31:0] o_ip_adr,
    output logic [15:0] o_port_nbr,
    output logic [15:0] o_drop_cnt
);

    localparam int            AW        = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

    typedef enum logic [1:0] {S_HDR, S_STORE, S_DROP, S_SEND} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] len_q, len_d;
    logic [31:0]   ip_adr_q, ip_adr_d;
    logic [15:0]   port_nbr_q, port_nbr_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          cnt_flag_q, cnt_flag_d;

    logic [7:0]    mem [DEPTH];

    logic          hdr_match;
    logic          hdr_fire;
    logic          in_fire;
    logic          out_fire;
    logic          mem_we;
    logic [15:0]   drop_cnt_inc;

`ifdef UDP_FILTER_ANY_SRC_EN
    assign hdr_match = (i_rx_udp_dest_port == PORT_NUMBER);
`else
    assign hdr_match = (i_rx_udp_ip_source_ip == IP_ADRESS) && (i_rx_udp_dest_port == PORT_NUMBER);
`endif

    // Handshake outputs are gated by reset so they read 0 for as long as reset is held.
    assign o_rx_udp_hdr_ready           = i_rst_n && (state_q == S_HDR);
    assign o_rx_udp_payload_axis_tready = i_rst_n && ((state_q == S_STORE) || (state_q == S_DROP));
    assign o_payload_axis_tvalid        = i_rst_n && (state_q == S_SEND);
    assign o_payload_axis_tlast         = o_payload_axis_tvalid && (rd_ptr_q == len_q - PTR_ONE);
    assign o_payload_axis_tdata         = mem[rd_ptr_q[AW-2:0]];

    assign hdr_fire = i_rx_udp_hdr_valid && o_rx_udp_hdr_ready;
    assign in_fire  = i_rx_udp_payload_axis_tvalid && o_rx_udp_payload_axis_tready;
    assign out_fire = o_payload_axis_tvalid && i_payload_axis_tready;
    assign mem_we   = in_fire && (state_q == S_STORE);

    assign drop_cnt_inc = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;

    assign o_ip_adr   = ip_adr_q;
    assign o_port_nbr = port_nbr_q;
    assign o_drop_cnt = drop_cnt_q;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        len_d      = len_q;
        ip_adr_d   = ip_adr_q;
        port_nbr_d = port_nbr_q;
        drop_cnt_d = drop_cnt_q;
        cnt_flag_d = cnt_flag_q;

        case (state_q)
            S_HDR: begin
                if (hdr_fire) begin
                    if (hdr_match) begin
                        ip_adr_d   = i_rx_udp_ip_source_ip;
                        port_nbr_d = i_rx_udp_dest_port;
                        wr_ptr_d   = '0;
                        state_d    = S_STORE;
                    end else begin
                        cnt_flag_d = 1'b0;
                        state_d    = S_DROP;
                    end
                end
            end
            S_STORE: begin
                if (in_fire) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (i_rx_udp_payload_axis_tlast) begin
                        if (i_rx_udp_payload_axis_tuser) begin
                            drop_cnt_d = drop_cnt_inc;
                            state_d    = S_HDR;
                        end else begin
                            len_d    = wr_ptr_q + PTR_ONE;
                            rd_ptr_d = '0;
                            state_d  = S_SEND;
                        end
                    end else if (wr_ptr_q == LAST_SLOT) begin
                        // Buffer full with more payload pending: discard the rest and count it.
                        cnt_flag_d = 1'b1;
                        state_d    = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (in_fire && i_rx_udp_payload_axis_tlast) begin
                    if (cnt_flag_q) drop_cnt_d = drop_cnt_inc;
                    state_d = S_HDR;
                end
            end
            S_SEND: begin
                if (out_fire) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    if (o_payload_axis_tlast) state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_HDR;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            len_q      <= '0;
            ip_adr_q   <= '0;
            port_nbr_q <= '0;
            drop_cnt_q <= '0;
            cnt_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            len_q      <= len_d;
            ip_adr_q   <= ip_adr_d;
            port_nbr_q <= port_nbr_d;
            drop_cnt_q <= drop_cnt_d;
            cnt_flag_q <= cnt_flag_d;
        end
    end

    // NOTE: the payload buffer is deliberately not reset; a byte is always written before it is replayed.
    always_ff @(posedge i_clk) begin
        if (mem_we) mem[wr_ptr_q[AW-2:0]] <= i_rx_udp_payload_axis_tdata;
    end

endmodule

// File: tb/tb_udp_cmd_rx_filter.sv
// Scoreboard bench for udp_cmd_rx_filter: packet-level reference model feeds an expected-byte queue,
// an independent monitor pops and compares every replayed byte.
module tb_udp_cmd_rx_filter;

    localparam int          DEPTH   = 64;
    localparam logic [31:0] IP_OK   = {8'd192, 8'd168, 8'd1, 8'd128};
    localparam logic [15:0] PORT_OK = 16'd1234;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic [31:0] ip;
        logic [15:0] port;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        hdr_valid = 1'b0;
    logic        hdr_ready;
    logic [31:0] src_ip = '0;
    logic [15:0] dst_port = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_user = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        ds_ready = 1'b0;
    logic [31:0] ip_adr;
    logic [15:0] port_nbr;
    logic [15:0] drop_cnt;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_drop = '0;
    logic [31:0] m_ip = '0;
    logic [15:0] m_port = '0;
    int          ready_mode = 0;

    always #5 clk = ~clk;

    udp_cmd_rx_filter #(.DEPTH(DEPTH), .IP_ADRESS(IP_OK), .PORT_NUMBER(PORT_OK)) dut (
        .i_clk                        (clk),
        .i_rst_n                      (rst_n),
        .i_rx_udp_hdr_valid           (hdr_valid),
        .o_rx_udp_hdr_ready           (hdr_ready),
        .i_rx_udp_ip_source_ip        (src_ip),
        .i_rx_udp_dest_port           (dst_port),
        .i_rx_udp_payload_axis_tdata  (in_data),
        .i_rx_udp_payload_axis_tvalid (in_valid),
        .i_rx_udp_payload_axis_tlast  (in_last),
        .i_rx_udp_payload_axis_tuser  (in_user),
        .o_rx_udp_payload_axis_tready (in_ready),
        .o_payload_axis_tdata         (out_data),
        .o_payload_axis_tvalid        (out_valid),
        .o_payload_axis_tlast         (out_last),
        .i_payload_axis_tready        (ds_ready),
        .o_ip_adr                     (ip_adr),
        .o_port_nbr                   (port_nbr),
        .o_drop_cnt                   (drop_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet-level reference: a matching packet either yields its bytes in order or bumps the drop count.
    task automatic model_packet(input logic [31:0] ip, input logic [15:0] port,
                                input byte_q_t bytes, input logic err);
        if (ip != IP_OK || port != PORT_OK) return;
        m_ip   = ip;
        m_port = port;
        if (err || bytes.size() > DEPTH) begin
            if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end else begin
            for (int i = 0; i < bytes.size(); i++) begin
                exp_t e;
                e.data = bytes[i];
                e.last = (i == bytes.size() - 1);
                e.ip   = ip;
                e.port = port;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_hdr(input logic [31:0] ip, input logic [15:0] port);
        int n = 0;
        hdr_valid = 1'b1;
        src_ip    = ip;
        dst_port  = port;
        forever begin
            @(negedge clk);
            if (hdr_ready) break;
            n++;
            if (n > 2000) begin
                check("hdr_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        hdr_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic user);
        int n = 0;
        if ($urandom_range(3) == 0) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_user  = user;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 2000) begin
                check("beat_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_user  = 1'b0;
    endtask

    task automatic send_packet(input logic [31:0] ip, input logic [15:0] port,
                               input byte_q_t bytes, input logic err);
        model_packet(ip, port, bytes, err);
        send_hdr(ip, port);
        for (int i = 0; i < bytes.size(); i++)
            send_beat(bytes[i], i == bytes.size() - 1, err && (i == bytes.size() - 1));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!hdr_ready && n < 3000);
        check({tag, "_idle"}, hdr_ready, 1);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_drop_cnt"}, drop_cnt, m_drop);
        check({tag, "_ip_adr"}, ip_adr, m_ip);
        check({tag, "_port_nbr"}, port_nbr, m_port);
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic make_seq(output byte_q_t q, input int len, input logic [7:0] base);
        q = {};
        for (int i = 0; i < len; i++) q.push_back(base + 8'(i));
    endtask

    // Downstream ready: random unless a test takes control of it.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) ds_ready = ($urandom_range(3) != 0);
        end
    end

    logic       stall_v = 1'b0;
    logic [7:0] stall_d = '0;
    logic       stall_l = 1'b0;

    // Monitor: a transfer seen at a falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_v <= 1'b0;
        end else begin
            if (stall_v) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, stall_d);
                check("stall_last", out_last, stall_l);
            end
            if (out_valid) check("hdr_ready_in_send", hdr_ready, 0);
            if (out_valid && ds_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 1, 0);
                end else begin
                    check("out_data", out_data, exp_q[0].data);
                    check("out_last", out_last, exp_q[0].last);
                    check("out_ip", ip_adr, exp_q[0].ip);
                    check("out_port", port_nbr, exp_q[0].port);
                    void'(exp_q.pop_front());
                end
            end
            stall_v <= out_valid && !ds_ready;
            stall_d <= out_data;
            stall_l <= out_last;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t q;
        int      n;

        #1 rst_n = 1'b0;
        #2;
        check("rst_hdr_ready", hdr_ready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_ip_adr", ip_adr, 0);
        check("rst_port_nbr", port_nbr, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_hdr_ready", hdr_ready, 1);
        @(posedge clk); #1;

        // 1: matching command replayed verbatim
        q = '{8'h3A, 8'h30, 8'h77, 8'h11, 8'h22, 8'h33, 8'h44};
        send_packet(IP_OK, PORT_OK, q, 1'b0);
        wait_idle("t1");
        check("t1_ip_const", ip_adr, 32'hC0A80180);
        check("t1_port_const", port_nbr, 16'h04D2);

        // 2: wrong source IP silently consumed
        q = '{8'h3A, 8'h31, 8'h72};
        send_packet({8'd192, 8'd168, 8'd1, 8'd129}, PORT_OK, q, 1'b0);
        wait_idle("t2");
        check("t2_ip_kept", ip_adr, 32'hC0A80180);

        // 3: errored packet counted
        make_seq(q, 5, 8'h50);
        send_packet(IP_OK, PORT_OK, q, 1'b1);
        wait_idle("t3");
        check("t3_drop_const", drop_cnt, 16'd1);

        // 4: exactly DEPTH accepted, DEPTH+1 dropped, then normal again
        make_seq(q, DEPTH, 8'h80);
        send_packet(IP_OK, PORT_OK, q, 1'b0);
        wait_idle("t4_full");
        make_seq(q, DEPTH + 1, 8'h10);
        send_packet(IP_OK, PORT_OK, q, 1'b0);
        wait_idle("t4_over");
        check("t4_drop_const", drop_cnt, 16'd2);
        make_seq(q, 4, 8'hE0);
        send_packet(IP_OK, PORT_OK, q, 1'b0);
        wait_idle("t4_after");

        // 5: downstream stall then toggling ready
        ready_mode = 1;
        ds_ready   = 1'b0;
        make_seq(q, 6, 8'hA0);
        send_packet(IP_OK, PORT_OK, q, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("t5_stalled_valid", out_valid, 1);
        check("t5_stalled_data", out_data, 8'hA0);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            ds_ready = ~ds_ready;
            @(posedge clk); #1;
            n++;
        end
        ds_ready   = 1'b0;
        ready_mode = 0;
        wait_idle("t5");

        // Randomized traffic: mixed match/mismatch, lengths straddling DEPTH, occasional errors
        for (int p = 0; p < 40; p++) begin
            logic [31:0] ip;
            logic [15:0] port;
            logic        err;
            int          len;
            ip   = ($urandom_range(4) == 0) ? $urandom : IP_OK;
            port = ($urandom_range(4) == 0) ? 16'($urandom) : PORT_OK;
            err  = ($urandom_range(7) == 0);
            len  = $urandom_range(DEPTH + 6, 1);
            q = {};
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            send_packet(ip, port, q, err);
            wait_idle("rnd");
        end

        // 6: asynchronous reset mid-store
        send_hdr(IP_OK, PORT_OK);
        send_beat(8'h3A, 1'b0, 1'b0);
        send_beat(8'h33, 1'b0, 1'b0);
        send_beat(8'h72, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_hdr_ready", hdr_ready, 0);
        check("t6_in_ready", in_ready, 0);
        check("t6_out_valid", out_valid, 0);
        check("t6_out_last", out_last, 0);
        check("t6_ip_adr", ip_adr, 0);
        check("t6_port_nbr", port_nbr, 0);
        check("t6_drop_cnt", drop_cnt, 0);
        m_drop = '0;
        m_ip   = '0;
        m_port = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        q = '{8'h3A, 8'h32, 8'h72};
        send_packet(IP_OK, PORT_OK, q, 1'b0);
        wait_idle("t6");
        check("t6_drop_const", drop_cnt, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
